// File: rtl/serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_tx
// Brief    : Buffers parallel sample words and serializes them LSB first
//            toward the FIR filter serial input, using a request/ready
//            handshake and a programmable idle gap between words.
// Revision : 1.0 - initial release
// ============================================================================

module serial_word_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_en,
    input  logic [DATA_WIDTH-1:0]             i_data,
    input  logic                              i_data_valid,
    output logic                              o_data_ready,
    output logic                              o_dout,
    output logic                              o_dout_valid,
    input  logic                              i_ready,
    output logic                              o_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (DATA_WIDTH > GAP_CYCLES) ? DATA_WIDTH : GAP_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_bit_last = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_gap_last = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [LVL_W-1:0] c_full     = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Async assert, clocked release: everything below sees a clean deassert.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [LVL_W-1:0]       r_level;
    logic [DATA_WIDTH-1:0]  r_shreg;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_shift_done;

    assign o_data_ready = (r_level != c_full);
    assign w_push       = i_data_valid && o_data_ready;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_shift_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_en && (r_level != '0)) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_ready) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == c_bit_last) begin
                    w_shift_done = 1'b1;
                    w_state_nxt  = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_cnt == c_gap_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // One counter serves both the bit index and the gap length; it is
    // cleared on the way into GAP so the gap count starts from zero.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (w_pop) begin
            r_shreg <= r_mem[r_rd_ptr];
            r_cnt   <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_shreg <= r_shreg >> 1;
            r_cnt   <= w_shift_done ? '0 : r_cnt + CNT_W'(1);
        end else if (r_state == ST_GAP) begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_dout_valid = (r_state == ST_REQ) || (r_state == ST_SHIFT);
    assign o_dout       = (r_state == ST_SHIFT) && r_shreg[0];
    assign o_busy       = (r_state != ST_IDLE);
    assign o_fifo_level = r_level;

endmodule

`default_nettype wire

// File: tb/tb_serial_word_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_tx
// Brief    : Directed bench for serial_word_tx plus a filter-side
//            deserializer scoreboard on a zero-gap instance.
// Revision : 1.0 - initial release
// ============================================================================

module tb_serial_word_tx;

    logic        tb_clk = 1'b0;
    logic        tb_rst_n;
    logic        en, dv, dready, dout, dvalid, rdy, busy;
    logic [23:0] data;
    logic [2:0]  level;

    logic        s_en, s_dv, s_dready, s_dout, s_dvalid, s_rdy, s_busy;
    logic [23:0] s_data;
    logic [2:0]  s_level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 tb_clk = ~tb_clk;

    serial_word_tx #(.DATA_WIDTH(24), .FIFO_DEPTH(4), .GAP_CYCLES(2)) dut (
        .i_clk        (tb_clk),
        .i_rst_n      (tb_rst_n),
        .i_en         (en),
        .i_data       (data),
        .i_data_valid (dv),
        .o_data_ready (dready),
        .o_dout       (dout),
        .o_dout_valid (dvalid),
        .i_ready      (rdy),
        .o_busy       (busy),
        .o_fifo_level (level)
    );

    serial_word_tx #(.DATA_WIDTH(24), .FIFO_DEPTH(4), .GAP_CYCLES(0)) dut0 (
        .i_clk        (tb_clk),
        .i_rst_n      (tb_rst_n),
        .i_en         (s_en),
        .i_data       (s_data),
        .i_data_valid (s_dv),
        .o_data_ready (s_dready),
        .o_dout       (s_dout),
        .o_dout_valid (s_dvalid),
        .i_ready      (s_rdy),
        .o_busy       (s_busy),
        .o_fifo_level (s_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [23:0] burst [4];
    logic [23:0] w;
    logic [23:0] exp_q [$];
    logic [23:0] acc;
    logic [23:0] exp_w;
    int          gap, seen_v, wr_idx, got, mstate, k, low_run;
    bit          seen_word, v, d, r;

    initial begin
        burst[0] = 24'h000001;
        burst[1] = 24'h800000;
        burst[2] = 24'hA5A5A5;
        burst[3] = 24'h5A5A5A;

        tb_rst_n = 1'b0;
        en = 1'b1; dv = 1'b0; data = '0; rdy = 1'b0;
        s_en = 1'b1; s_dv = 1'b0; s_data = '0; s_rdy = 1'b0;
        repeat (3) @(negedge tb_clk);

        // ---- reset state
        check("rst_dout",   dout,   0);
        check("rst_valid",  dvalid, 0);
        check("rst_busy",   busy,   0);
        check("rst_level",  level,  0);
        check("rst_dready", dready, 1);
        tb_rst_n = 1'b1;
        repeat (3) @(negedge tb_clk);

        // ---- single word, ready held high
        rdy = 1'b1;
        w = 24'h123456;
        data = w; dv = 1'b1;
        @(negedge tb_clk);
        dv = 1'b0;
        check("single_level_after_write", level, 1);
        check("single_valid_low_at_write", dvalid, 0);
        @(negedge tb_clk);
        check("single_valid_rise", dvalid, 1);
        check("single_req_dout", dout, 0);
        check("single_level_after_pop", level, 0);
        @(negedge tb_clk);
        for (int i = 0; i < 24; i++) begin
            check("single_bit", {dvalid, dout}, {1'b1, w[i]});
            @(negedge tb_clk);
        end
        check("single_valid_fall", dvalid, 0);
        check("single_busy_in_gap", busy, 1);
        @(negedge tb_clk);
        check("single_busy_gap2", busy, 1);
        @(negedge tb_clk);
        check("single_busy_fall", busy, 0);

        // ---- delayed ready
        rdy = 1'b0;
        data = 24'hFFFFFF; dv = 1'b1;
        @(negedge tb_clk);
        dv = 1'b0;
        @(negedge tb_clk);
        for (int i = 0; i < 10; i++) begin
            check("delay_req_hold", {dvalid, dout}, 2'b10);
            @(negedge tb_clk);
        end
        rdy = 1'b1;
        @(negedge tb_clk);
        for (int i = 0; i < 24; i++) begin
            check("delay_bit", {dvalid, dout}, 2'b11);
            if (i == 5) rdy = 1'b0;
            @(negedge tb_clk);
        end
        check("delay_valid_fall", dvalid, 0);
        repeat (3) @(negedge tb_clk);

        // ---- back-to-back burst into a held-off FIFO
        rdy = 1'b1;
        en  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("b2b_ready_before_fill", dready, 1);
            data = burst[i]; dv = 1'b1;
            @(negedge tb_clk);
        end
        dv = 1'b0;
        check("b2b_ready_full", dready, 0);
        check("b2b_level_full", level, 4);
        en = 1'b1;
        @(negedge tb_clk);
        for (int wi = 0; wi < 4; wi++) begin
            w = burst[wi];
            check("b2b_req", dvalid, 1);
            check("b2b_level", level, 3 - wi);
            @(negedge tb_clk);
            for (int i = 0; i < 24; i++) begin
                check("b2b_bit", {dvalid, dout}, {1'b1, w[i]});
                @(negedge tb_clk);
            end
            if (wi < 3) begin
                gap = 0;
                while (!dvalid && gap < 20) begin
                    gap++;
                    @(negedge tb_clk);
                end
                check("b2b_gap", gap, 3);
            end
        end
        repeat (3) @(negedge tb_clk);

        // ---- enable gating
        en = 1'b0;
        w = 24'h00F00F;
        data = w; dv = 1'b1;
        @(negedge tb_clk);
        data = 24'h0F0F0F;
        @(negedge tb_clk);
        dv = 1'b0;
        repeat (3) @(negedge tb_clk);
        check("en_no_req", dvalid, 0);
        check("en_not_busy", busy, 0);
        check("en_level2", level, 2);
        en = 1'b1;
        @(negedge tb_clk);
        check("en_req", dvalid, 1);
        check("en_level1", level, 1);
        @(negedge tb_clk);
        for (int i = 0; i < 24; i++) begin
            check("en_bit", {dvalid, dout}, {1'b1, w[i]});
            if (i == 3) en = 1'b0;
            @(negedge tb_clk);
        end
        repeat (8) @(negedge tb_clk);
        check("en_hold_valid", dvalid, 0);
        check("en_hold_busy", busy, 0);
        check("en_hold_level", level, 1);
        en = 1'b1;
        @(negedge tb_clk);
        check("en_resume", dvalid, 1);
        repeat (30) @(negedge tb_clk);
        check("en_drained", level, 0);

        // ---- reset in the middle of a word with two words queued
        en = 1'b0;
        w = 24'h123456;
        data = w; dv = 1'b1;
        @(negedge tb_clk);
        data = 24'h111111;
        @(negedge tb_clk);
        data = 24'h222222;
        @(negedge tb_clk);
        dv = 1'b0;
        en = 1'b1;
        @(negedge tb_clk);
        @(negedge tb_clk);
        repeat (10) @(negedge tb_clk);
        check("rstmid_bit10", {dvalid, dout}, {1'b1, w[10]});
        #2 tb_rst_n = 1'b0;
        #1;
        check("rstmid_async_out", {dvalid, dout, busy}, 3'b000);
        @(negedge tb_clk);
        tb_rst_n = 1'b1;
        repeat (4) @(negedge tb_clk);
        check("rstmid_level", level, 0);
        check("rstmid_dready", dready, 1);
        seen_v = 0;
        repeat (30) begin
            @(negedge tb_clk);
            if (dvalid) seen_v++;
        end
        check("rstmid_no_output", seen_v, 0);

        // ---- scoreboard on the zero-gap instance
        wr_idx = 0; got = 0; mstate = 0; k = 0; low_run = 0; seen_word = 1'b0; acc = '0;
        for (int cyc = 0; cyc < 20000 && got < 220; cyc++) begin
            @(negedge tb_clk);
            v = s_dvalid;
            d = s_dout;
            if (!v) begin
                low_run++;
            end else if (low_run > 0) begin
                if (seen_word) check("sb_gap", low_run, 1);
                seen_word = 1'b1;
                low_run = 0;
            end
            if (mstate == 0) begin
                if (v) check("sb_req_dout", d, 0);
                r = ($urandom_range(0, 2) == 0);
                s_rdy = r;
                if (v && r) begin
                    mstate = 1;
                    k = 0;
                end
            end else begin
                check("sb_valid_in_word", v, 1);
                acc[k] = d;
                k++;
                s_rdy = 1'($urandom_range(0, 1));
                if (k == 24) begin
                    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
                    check("sb_word", acc, exp_w);
                    got++;
                    mstate = 0;
                end
            end
            if (wr_idx < 220 && s_dready) begin
                s_data = 24'($urandom);
                s_dv   = 1'b1;
                exp_q.push_back(s_data);
                wr_idx++;
            end else begin
                s_dv = 1'b0;
            end
        end
        check("sb_word_count", got, 220);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
